// File: rtl/i2s_pkg.sv
// i2s_pkg: shared I2S frame geometry, bit index type and sample slice helper.
// Used by i2s_clock_gen and i2s_multi_receiver.
package i2s_pkg;
    localparam int SLOT_BITS  = 32;
    localparam int FRAME_BITS = 64;

    typedef logic [5:0] bit_index_t;

    // Offset of (line, channel) inside the packed sample vector; right = 1 selects the right channel.
    function automatic int slice_offset(input int line, input logic right, input int width);
        return (2 * line + (right ? 1 : 0)) * width;
    endfunction
endpackage

// File: rtl/i2s_clock_gen.sv
// i2s_clock_gen: I2S bit clock, word select and bit position generator.
// Ports:
//   clk_i        system clock
//   rst_i        synchronous active-high reset
//   bclk_o       bit clock, 2*CLOCK_DIVISOR clk_i cycles per period
//   lrclk_o      word select (0 = left slot), changes only on BCLK falls
//   bit_index_o  position 0..63 within the frame
//   fall_tick_o  high in the cycle whose edge drives BCLK from high to low
module i2s_clock_gen import i2s_pkg::*; #(
    parameter int CLOCK_DIVISOR = 12
) (
    input  logic       clk_i,
    input  logic       rst_i,
    output logic       bclk_o,
    output logic       lrclk_o,
    output logic [5:0] bit_index_o,
    output logic       fall_tick_o
);
    localparam int PW = $clog2(CLOCK_DIVISOR);

    logic [PW-1:0] phase_q, phase_d;
    logic          bclk_q, bclk_d;
    bit_index_t    idx_q, idx_d;
    logic          tc, fall;

    always_comb begin
        tc      = phase_q == PW'(CLOCK_DIVISOR - 1);
        fall    = tc & bclk_q;
        phase_d = tc ? '0 : phase_q + 1'b1;
        bclk_d  = tc ? ~bclk_q : bclk_q;
        idx_d   = fall ? idx_q + 1'b1 : idx_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            phase_q <= '0;
            bclk_q  <= 1'b0;
            idx_q   <= '0;
        end else begin
            phase_q <= phase_d;
            bclk_q  <= bclk_d;
            idx_q   <= idx_d;
        end
    end

    assign bclk_o      = bclk_q;
    assign lrclk_o     = idx_q[5];
    assign bit_index_o = idx_q;
    assign fall_tick_o = fall;
endmodule

// File: rtl/i2s_multi_receiver.sv
// i2s_multi_receiver: I2S master receiver for NUM_LINES stereo data lines with frame handshake.
// Ports:
//   clock_in, reset_in       system clock, synchronous active-high reset
//   i2s_bclk_out, i2s_lrclk_out  generated bit clock and word select
//   i2s_data_in              one serial data bit per line
//   samples_out              line k left at [2k*W +: W], right at [(2k+1)*W +: W]
//   valid_out / ready_in     frame handshake
//   overflow_out             sticky, set when an undelivered frame is overwritten
//   clear_overflow_in        pulse clearing overflow_out
//   frame_count_out          16-bit count of loaded frames, only with I2S_RX_FRAME_COUNT_EN
module i2s_multi_receiver import i2s_pkg::*; #(
    parameter int CLOCK_DIVISOR  = 12,
    parameter int SAMPLE_WIDTH   = 16,
    parameter int NUM_LINES      = 2,
    parameter int DISCARD_FRAMES = 2
) (
    input  logic                                clock_in,
    input  logic                                reset_in,
    output logic                                i2s_bclk_out,
    output logic                                i2s_lrclk_out,
    input  logic [NUM_LINES-1:0]                i2s_data_in,
    output logic [2*NUM_LINES*SAMPLE_WIDTH-1:0] samples_out,
    output logic                                valid_out,
    input  logic                                ready_in,
    output logic                                overflow_out,
`ifdef I2S_RX_FRAME_COUNT_EN
    output logic [15:0]                         frame_count_out,
`endif
    input  logic                                clear_overflow_in
);
    localparam int TW = 2 * NUM_LINES * SAMPLE_WIDTH;
    localparam int PB = $clog2(SLOT_BITS);

    logic [5:0]           bit_index;
    logic                 fall_tick;
    logic [NUM_LINES-1:0] sync1_q, sync2_q;
    logic [TW-1:0]        shift_q, shift_d, samples_q, samples_d;
    logic                 valid_q, valid_d, ovf_q, ovf_d;
    logic [31:0]          discard_q, discard_d;
    logic [PB-1:0]        pos;
    logic                 in_slot, frame_done, load;

    i2s_clock_gen #(.CLOCK_DIVISOR(CLOCK_DIVISOR)) u_clk (
        .clk_i      (clock_in),
        .rst_i      (reset_in),
        .bclk_o     (i2s_bclk_out),
        .lrclk_o    (i2s_lrclk_out),
        .bit_index_o(bit_index),
        .fall_tick_o(fall_tick)
    );

    always_comb begin
        pos        = bit_index[PB-1:0];
        // Position 0 is the I2S delay bit; positions past SAMPLE_WIDTH are dropped.
        in_slot    = fall_tick && pos != '0 && {1'b0, pos} <= (PB+1)'(SAMPLE_WIDTH);
        shift_d    = shift_q;
        for (int k = 0; k < NUM_LINES; k++)
            if (in_slot)
                shift_d[slice_offset(k, bit_index[5], SAMPLE_WIDTH) +: SAMPLE_WIDTH] =
                    SAMPLE_WIDTH'({shift_q[slice_offset(k, bit_index[5], SAMPLE_WIDTH) +: SAMPLE_WIDTH], sync2_q[k]});
        frame_done = fall_tick && bit_index == bit_index_t'(FRAME_BITS - 1);
        load       = frame_done && discard_q == 0;
        discard_d  = (frame_done && discard_q != 0) ? discard_q - 1 : discard_q;
        // Load from shift_d so a bit captured on the final tick is part of the frame.
        samples_d  = load ? shift_d : samples_q;
        valid_d    = load || (valid_q && !ready_in);
        // A new overflow wins over a simultaneous clear.
        ovf_d      = (load && valid_q && !ready_in) || (ovf_q && !clear_overflow_in);
    end

    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            shift_q   <= '0;
            samples_q <= '0;
            valid_q   <= 1'b0;
            ovf_q     <= 1'b0;
            discard_q <= 32'(DISCARD_FRAMES);
        end else begin
            sync1_q   <= i2s_data_in;
            sync2_q   <= sync1_q;
            shift_q   <= shift_d;
            samples_q <= samples_d;
            valid_q   <= valid_d;
            ovf_q     <= ovf_d;
            discard_q <= discard_d;
        end
    end

`ifdef I2S_RX_FRAME_COUNT_EN
    logic [15:0] fc_q, fc_d;

    assign fc_d = load ? fc_q + 16'd1 : fc_q;

    always_ff @(posedge clock_in) begin
        if (reset_in)
            fc_q <= '0;
        else
            fc_q <= fc_d;
    end

    assign frame_count_out = fc_q;
`endif

    assign samples_out  = samples_q;
    assign valid_out    = valid_q;
    assign overflow_out = ovf_q;
endmodule

// File: doc/i2s_multi_receiver.md
# i2s_multi_receiver

Parametrised I2S master-receiver for microphone arrays: generates BCLK/LRCLK and deserialises NUM_LINES data lines, each carrying a left/right pair, into SAMPLE_WIDTH-bit words. It delivers all 2*NUM_LINES samples of a frame at once over a valid/ready handshake, with a hold register and a sticky overflow flag. It sits between the microphone pins and the downstream DSP/beamforming pipeline, and is the multi-line, back-pressure-aware successor to the single-pair receiver.

## Interface
Parameters:
- CLOCK_DIVISOR, 12: clock_in cycles per BCLK half-period. Must be ≥ 4.
- SAMPLE_WIDTH, 16: bits kept per channel, MSB-first from the slot. Range 1..31.
- NUM_LINES, 2: number of I2S data lines. Each line carries 2 channels.
- DISCARD_FRAMES, 2: completed frames dropped after reset, for microphone settling. 0 allowed.

Ports:
- clock_in  in  1  system clock (100 MHz).
- reset_in  in  1  synchronous, active-high reset.
- i2s_bclk_out  out  1  bit clock; period 2*CLOCK_DIVISOR clock_in cycles.
- i2s_lrclk_out  out  1  word select; 0 = left slot, 1 = right slot; period 64 BCLK.
- i2s_data_in  in  NUM_LINES  serial data, one bit per line.
- samples_out  out  2*NUM_LINES*SAMPLE_WIDTH  line k left at [2k*W +: W], right at [(2k+1)*W +: W].
- valid_out  out  1  samples_out holds an undelivered frame.
- ready_in  in  1  consumer accepts the frame when valid_out && ready_in.
- overflow_out  out  1  sticky: a frame was overwritten before it was accepted.
- clear_overflow_in  in  1  single-cycle pulse; clears overflow_out.

## Operation
- Phase counter 0..CLOCK_DIVISOR-1; at terminal count BCLK toggles and the counter returns to 0.
- Fall tick: cycle in which BCLK is registered high→low.
- 6-bit bit_index increments on every fall tick and wraps 63→0. i2s_lrclk_out = bit_index[5], registered, so LRCLK changes only on BCLK falls.
- i2s_data_in passes through a 2-flop synchroniser per line. Data is sampled on the fall tick, using the current bit_index before it increments.
- Slot position p = bit_index[4:0]:
  - p = 0 is the I2S delay bit and is ignored.
  - p = 1..SAMPLE_WIDTH shift into that line's left or right register, chosen by bit_index[5].
  - p > SAMPLE_WIDTH is ignored.
- Frame completion is the fall tick at bit_index = 63. On that tick:
  - If discard_count > 0: decrement it. No output change.
  - Otherwise, if the output is free (valid_out = 0, or ready_in = 1 in that cycle): load samples_out and set valid_out = 1.
  - Otherwise (valid_out = 1 and ready_in = 0): load samples_out (newest wins), keep valid_out = 1, and set overflow_out = 1.
- Handshake: when valid_out && ready_in with no frame completing, clear valid_out next cycle. samples_out holds its value while valid_out = 1 and ready_in = 0.
- Overflow vs clear in the same cycle: setting overflow takes priority over clear_overflow_in.
- Shift registers are not cleared between frames; bits beyond SAMPLE_WIDTH never reach them.

## Timing
- Reset values: i2s_bclk_out 0, i2s_lrclk_out 0, samples_out 0, valid_out 0, overflow_out 0. Phase, bit_index and shift registers reset to 0; discard_count resets to DISCARD_FRAMES.
- Reset mid-frame aborts the frame. The partial frame is never delivered.
- First BCLK rise occurs CLOCK_DIVISOR cycles after reset deasserts.
- Frame period: 128*CLOCK_DIVISOR cycles.
- samples_out and valid_out update on the same clock edge that drives BCLK low at the end of bit 63.
- Sampled pin value is 2–3 cycles old and lies inside the BCLK high half-period; this requires CLOCK_DIVISOR ≥ 4.
- First delivered frame: valid_out rises at cycle (DISCARD_FRAMES+1)*128*CLOCK_DIVISOR after reset deasserts.

## Configuration
- I2S_RX_FRAME_COUNT_EN defined: adds port frame_count_out (out, 16 bits).
  - Resets to 0.
  - Increments on every frame loaded into samples_out, including overwriting loads.
  - Wraps at 0xFFFF→0.
- Undefined: no port, no counter logic.

## Structure
- Package i2s_pkg holds:
  - SLOT_BITS = 32 and FRAME_BITS = 64.
  - Typedef bit_index_t (logic [5:0]).
  - Function computing the sample-slice offset for (line, channel).
- Sub-module i2s_clock_gen: phase counter, BCLK, bit_index, LRCLK and the fall-tick strobe. Shared later with an I2S transmitter.

## Test plan
- Reset release, CLOCK_DIVISOR=12: BCLK period 24 cycles, LRCLK period 1536 cycles, first LRCLK rise after 32 BCLK falls.
- NUM_LINES=2, SAMPLE_WIDTH=16, DISCARD_FRAMES=0, ready_in=1; model drives line0 L=0x8001, R=0x7FFE and line1 L=0x1234, R=0xABCD at I2S timing -> one valid_out pulse per 1536 cycles, samples_out = {ABCD,1234,7FFE,8001}.
- SAMPLE_WIDTH=24 with 32-bit slots whose low 8 bits are 0xFF -> outputs contain only bits 31..8 of each slot.
- ready_in held 0 across 3 frames (values 1, 2, 3) -> valid_out stays 1, samples_out = frame 3, overflow_out = 1; clear_overflow_in pulse -> 0; clear on the same cycle as a new overflow -> remains 1.
- DISCARD_FRAMES=2 -> first valid_out at cycle 3*1536. Reset asserted at bit_index 40 -> no delivery; counting restarts with a full discard.
- I2S_RX_FRAME_COUNT_EN defined -> frame_count_out = 5 after 5 loads; preloaded 0xFFFF wraps to 0.
